video_mem_writer: RTL and testbench

//   CPU-side write port for the tile renderer's picture memories (tilemap, palmap, paldef, tiledef).

---
 rtl/video_pkg.sv | 56 +++++
 rtl/vmw_addr_decode.sv | 53 +++++
 rtl/video_mem_writer.sv | 206 ++++++++++++++++++++
 tb/tb_video_mem_writer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared constants, state encoding and decode record for the video memory write port.
// Address map for the optional auto-increment registers is enabled by VMW_AUTOINC_EN.
package video_pkg;

  localparam int MAP_ENTRIES  = 1200;
  localparam int PAL_ENTRIES  = 16;
  localparam int TILE_ENTRIES = 64;
  localparam int MEM_IDX_W    = 11;

  localparam int TILEMAP_BASE  = 'h0000;
  localparam int PALMAP_BASE   = 'h0800;
  localparam int PALDEF_BASE   = 'h1000;
  localparam int TILEDEF_BASE  = 'h1100;
  localparam int TILEDEF_LIMIT = 'h11FF;
  localparam int CTRL_ADDR     = 'h1F00;
  localparam int PTR_ADDR      = 'h1F01;
  localparam int DATA_ADDR     = 'h1F02;

  localparam int WE_TILEMAP = 0;
  localparam int WE_PALMAP  = 1;
  localparam int WE_PALDEF  = 2;
  localparam int WE_TILEDEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR
  } state_e;

  typedef struct packed {
    logic [3:0]           mem_sel;
    logic                 ctrl_sel;
    logic                 ptr_sel;
    logic                 data_sel;
    logic [MEM_IDX_W-1:0] index;
    logic [1:0]           tile_word;
    logic                 in_range;
  } decode_t;

  // Narrow memories keep only the low bits of the CPU word.
  function automatic logic [63:0] align_narrow(input logic [3:0] sel, input logic [15:0] wdata);
    logic [63:0] d;
    d = '0;
    if (sel[WE_TILEMAP]) begin
      d[5:0] = wdata[5:0];
    end else if (sel[WE_PALMAP]) begin
      d[7:0] = wdata[7:0];
    end else if (sel[WE_PALDEF]) begin
      d[11:0] = wdata[11:0];
    end else begin
      d[15:0] = wdata;
    end
    return d;
  endfunction

endpackage

// File: rtl/vmw_addr_decode.sv
// Combinational CPU word-address decoder: region one-hot, entry index and tile word.
// The PTR/DATA registers decode only when VMW_AUTOINC_EN is defined.
module vmw_addr_decode #(
  parameter int ADDR_W      = 13,
  parameter int MAP_ENTRIES = 1200
) (
  input  logic [ADDR_W-1:0] addr,
  output video_pkg::decode_t dec
);
  import video_pkg::*;

  logic [ADDR_W-1:0] off_tilemap;
  logic [ADDR_W-1:0] off_palmap;
  logic [ADDR_W-1:0] off_paldef;
  logic [ADDR_W-1:0] off_tiledef;

  always_comb begin
    off_tilemap = addr - ADDR_W'(TILEMAP_BASE);
    off_palmap  = addr - ADDR_W'(PALMAP_BASE);
    off_paldef  = addr - ADDR_W'(PALDEF_BASE);
    off_tiledef = addr - ADDR_W'(TILEDEF_BASE);
  end

  // Tiledef packs four 16-bit words per 64-bit row, so the row index drops the word bits.
  always_comb begin
    dec = '0;
    if (addr < ADDR_W'(TILEMAP_BASE + MAP_ENTRIES)) begin
      dec.mem_sel[WE_TILEMAP] = 1'b1;
      dec.index               = MEM_IDX_W'(off_tilemap);
    end else if (addr >= ADDR_W'(PALMAP_BASE) && addr < ADDR_W'(PALMAP_BASE + MAP_ENTRIES)) begin
      dec.mem_sel[WE_PALMAP] = 1'b1;
      dec.index              = MEM_IDX_W'(off_palmap);
    end else if (addr >= ADDR_W'(PALDEF_BASE) && addr < ADDR_W'(PALDEF_BASE + PAL_ENTRIES)) begin
      dec.mem_sel[WE_PALDEF] = 1'b1;
      dec.index              = MEM_IDX_W'(off_paldef);
    end else if (addr >= ADDR_W'(TILEDEF_BASE) && addr <= ADDR_W'(TILEDEF_LIMIT)) begin
      dec.mem_sel[WE_TILEDEF] = 1'b1;
      dec.index               = MEM_IDX_W'(off_tiledef >> 2);
      dec.tile_word           = off_tiledef[1:0];
    end else if (addr == ADDR_W'(CTRL_ADDR)) begin
      dec.ctrl_sel = 1'b1;
    end
`ifdef VMW_AUTOINC_EN
    else if (addr == ADDR_W'(PTR_ADDR)) begin
      dec.ptr_sel = 1'b1;
    end else if (addr == ADDR_W'(DATA_ADDR)) begin
      dec.data_sel = 1'b1;
    end
`endif
    dec.in_range = (|dec.mem_sel) | dec.ctrl_sel | dec.ptr_sel | dec.data_sel;
  end

endmodule

// File: rtl/video_mem_writer.sv
// CPU write port for the tile renderer memories: decode, tile row assembly and hardware clear.
// Define VMW_AUTOINC_EN to add the PTR (0x1F01) / DATA (0x1F02) auto-increment registers.
module video_mem_writer #(
  parameter int ADDR_W      = 13,
  parameter int MAP_ENTRIES = 1200,
  parameter int AUTO_CLEAR  = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              busy,
  output logic [3:0]        mem_we,
  output logic [10:0]       mem_addr,
  output logic [63:0]       mem_data
);
  import video_pkg::*;

  localparam logic [MEM_IDX_W-1:0] LAST_ENTRY = MEM_IDX_W'(MAP_ENTRIES - 1);

  state_e               state_q, state_d;
  logic                 clear_pend_q, clear_pend_d;
  logic [MEM_IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic                 req_we_q, req_we_d;
  logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
  logic [15:0]          req_wdata_q, req_wdata_d;
  logic [2:0][15:0]     stage_q, stage_d;
  logic                 ack_q, ack_d;
  logic [15:0]          rdata_q, rdata_d;
  logic                 busy_q, busy_d;
  logic [3:0]           mem_we_q, mem_we_d;
  logic [MEM_IDX_W-1:0] mem_addr_q, mem_addr_d;
  logic [63:0]          mem_data_q, mem_data_d;
`ifdef VMW_AUTOINC_EN
  logic [ADDR_W-1:0]    ptr_q, ptr_d;
`endif

  logic [ADDR_W-1:0]    eff_addr;
  decode_t              dec;

  // A DATA write is redirected to the address held in PTR; everything else decodes as issued.
  always_comb begin
`ifdef VMW_AUTOINC_EN
    eff_addr = (req_we_q && req_addr_q == ADDR_W'(DATA_ADDR)) ? ptr_q : req_addr_q;
`else
    eff_addr = req_addr_q;
`endif
  end

  vmw_addr_decode #(
    .ADDR_W      (ADDR_W),
    .MAP_ENTRIES (MAP_ENTRIES)
  ) u_decode (
    .addr (eff_addr),
    .dec  (dec)
  );

  always_comb begin
    state_d      = state_q;
    clear_pend_d = clear_pend_q;
    clr_cnt_d    = clr_cnt_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    stage_d      = stage_q;
    ack_d        = 1'b0;
    rdata_d      = '0;
    busy_d       = 1'b0;
    mem_we_d     = '0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
`ifdef VMW_AUTOINC_EN
    ptr_d        = ptr_q;
`endif

    unique case (state_q)
      // Ignoring req during the ack cycle keeps a slow-to-drop CPU from being served twice.
      IDLE: begin
        if (clear_pend_q) begin
          clear_pend_d = 1'b0;
          clr_cnt_d    = '0;
          state_d      = CLEAR;
        end else if (cpu_req && !ack_q) begin
          req_we_d    = cpu_we;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          state_d     = WRITE;
        end
      end

      WRITE: begin
        ack_d   = 1'b1;
        state_d = IDLE;
        if (req_we_q && dec.in_range) begin
          if (dec.mem_sel[WE_TILEDEF]) begin
            unique case (dec.tile_word)
              2'd0: stage_d[0] = req_wdata_q;
              2'd1: stage_d[1] = req_wdata_q;
              2'd2: stage_d[2] = req_wdata_q;
              default: begin
                mem_we_d[WE_TILEDEF] = 1'b1;
                mem_addr_d           = dec.index;
                mem_data_d           = {req_wdata_q, stage_q[2], stage_q[1], stage_q[0]};
              end
            endcase
          end else if (|dec.mem_sel) begin
            mem_we_d   = dec.mem_sel;
            mem_addr_d = dec.index;
            mem_data_d = align_narrow(dec.mem_sel, req_wdata_q);
          end else if (dec.ctrl_sel && req_wdata_q[0]) begin
            clr_cnt_d = '0;
            state_d   = CLEAR;
          end
`ifdef VMW_AUTOINC_EN
          else if (dec.ptr_sel) begin
            ptr_d = ADDR_W'(req_wdata_q);
          end
`endif
        end else if (!req_we_q && dec.in_range) begin
          if (dec.ctrl_sel) begin
            rdata_d = {15'b0, busy_q};
          end
`ifdef VMW_AUTOINC_EN
          else if (dec.ptr_sel) begin
            rdata_d = 16'(ptr_q);
          end
`endif
        end
`ifdef VMW_AUTOINC_EN
        if (req_we_q && req_addr_q == ADDR_W'(DATA_ADDR)) begin
          ptr_d = ptr_q + 1'b1;
        end
`endif
      end

      // Palette and tile memories are shorter than the maps, so their strobes drop out early.
      CLEAR: begin
        busy_d               = 1'b1;
        mem_we_d[WE_TILEMAP] = 1'b1;
        mem_we_d[WE_PALMAP]  = 1'b1;
        mem_we_d[WE_PALDEF]  = (clr_cnt_q < MEM_IDX_W'(PAL_ENTRIES));
        mem_we_d[WE_TILEDEF] = (clr_cnt_q < MEM_IDX_W'(TILE_ENTRIES));
        mem_addr_d           = clr_cnt_q;
        mem_data_d           = '0;
        if (clr_cnt_q == LAST_ENTRY) begin
          clr_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      clear_pend_q <= (AUTO_CLEAR != 0);
      clr_cnt_q    <= '0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      stage_q      <= '0;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
`ifdef VMW_AUTOINC_EN
      ptr_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      clear_pend_q <= clear_pend_d;
      clr_cnt_q    <= clr_cnt_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      stage_q      <= stage_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
`ifdef VMW_AUTOINC_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  assign cpu_ack   = ack_q;
  assign cpu_rdata = rdata_q;
  assign busy      = busy_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;

endmodule

// File: tb/tb_video_mem_writer.sv
// Directed bench for video_mem_writer: memory writes are predicted into a scoreboard queue
// and matched in order against the strobes the DUT produces.
`timescale 1ns/1ps
module tb_video_mem_writer;

  typedef struct packed {
    logic [3:0]  we;
    logic [10:0] addr;
    logic [63:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        busy;
  logic [3:0]  mem_we;
  logic [10:0] mem_addr;
  logic [63:0] mem_data;

  int  checks = 0;
  int  errors = 0;
  int  busy_cycles = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  video_mem_writer dut (
    .clk       (clk),
    .resetn    (resetn),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data)
  );

  task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushWrite(input logic [3:0] we, input logic [10:0] addr, input logic [63:0] data);
    wr_t e;
    e.we   = we;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pushClear();
    for (int n = 0; n < 1200; n++) begin
      if (n < 16)      pushWrite(4'b1111, 11'(n), 64'd0);
      else if (n < 64) pushWrite(4'b1011, 11'(n), 64'd0);
      else             pushWrite(4'b0011, 11'(n), 64'd0);
    end
  endtask

  // Called on a falling edge: drives the request at once, waits for ack, drops req on ack.
  task automatic applyStimulus(input string tag, input logic [12:0] addr, input logic we,
                               input logic [15:0] wdata, input logic [15:0] exp_rdata,
                               input int min_lat, input int max_lat);
    int lat;
    lat = 0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    do begin
      @(negedge clk);
      lat++;
    end while (cpu_ack !== 1'b1 && lat < 3000);
    checkOutput({tag, "_ack"}, 80'(cpu_ack), 80'(1));
    if (min_lat == max_lat) checkOutput({tag, "_lat"}, 80'(lat), 80'(min_lat));
    else                    checkOutput({tag, "_latrange"}, 80'(lat >= min_lat && lat <= max_lat), 80'(1));
    if (!we) checkOutput({tag, "_rdata"}, 80'(cpu_rdata), 80'(exp_rdata));
    cpu_req = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_ackpulse"}, 80'(cpu_ack), 80'(0));
  endtask

  task automatic waitClear(input string tag);
    repeat (1250) @(negedge clk);
    checkOutput({tag, "_busycycles"}, 80'(busy_cycles), 80'(1200));
    checkOutput({tag, "_drain"}, 80'(exp_q.size()), 80'(0));
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (busy === 1'b1) busy_cycles++;
    if (mem_we !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", 80'(mem_we), 80'(0));
      end else begin
        e = exp_q.pop_front();
        checkOutput("mem_write", 80'({mem_we, mem_addr, mem_data}), 80'(e));
      end
    end
  end

  initial begin
    resetn    = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ack",   80'(cpu_ack),   80'(0));
    checkOutput("rst_rdata", 80'(cpu_rdata), 80'(0));
    checkOutput("rst_we",    80'(mem_we),    80'(0));
    checkOutput("rst_addr",  80'(mem_addr),  80'(0));
    checkOutput("rst_data",  80'(mem_data),  80'(0));
    checkOutput("rst_busy",  80'(busy),      80'(0));

    $display("[TB] auto clear after reset release");
    pushClear();
    busy_cycles = 0;
    resetn = 1'b1;
    waitClear("autoclr");

    $display("[TB] mapped writes");
    pushWrite(4'b0001, 11'd5, 64'h3F);
    applyStimulus("tilemap5", 13'h0005, 1'b1, 16'h003F, 16'h0, 2, 2);
    pushWrite(4'b0001, 11'd1199, 64'h01);
    applyStimulus("tilemap_last", 13'h04AF, 1'b1, 16'hFFC1, 16'h0, 2, 2);
    pushWrite(4'b0010, 11'd5, 64'hAB);
    applyStimulus("palmap5", 13'h0805, 1'b1, 16'h12AB, 16'h0, 2, 2);
    pushWrite(4'b0010, 11'd1199, 64'h7E);
    applyStimulus("palmap_last", 13'h0CAF, 1'b1, 16'hFF7E, 16'h0, 2, 2);
    pushWrite(4'b0100, 11'd15, 64'h123);
    applyStimulus("paldef15", 13'h100F, 1'b1, 16'hF123, 16'h0, 2, 2);

    $display("[TB] tile row assembly");
    applyStimulus("tile_w0", 13'h1104, 1'b1, 16'h1111, 16'h0, 2, 2);
    applyStimulus("tile_w1", 13'h1105, 1'b1, 16'h2222, 16'h0, 2, 2);
    applyStimulus("tile_w2", 13'h1106, 1'b1, 16'h3333, 16'h0, 2, 2);
    pushWrite(4'b1000, 11'd1, 64'h4444_3333_2222_1111);
    applyStimulus("tile_w3", 13'h1107, 1'b1, 16'h4444, 16'h0, 2, 2);
    pushWrite(4'b1000, 11'd63, 64'h5555_3333_2222_1111);
    applyStimulus("tile_partial", 13'h11FF, 1'b1, 16'h5555, 16'h0, 2, 2);

    $display("[TB] unmapped and control");
    applyStimulus("unmap_04b0", 13'h04B0, 1'b1, 16'hBEEF, 16'h0, 2, 2);
    applyStimulus("unmap_1f10", 13'h1F10, 1'b1, 16'hBEEF, 16'h0, 2, 2);
    applyStimulus("unmap_1010", 13'h1010, 1'b1, 16'hBEEF, 16'h0, 2, 2);
    applyStimulus("ctrl_nop",   13'h1F00, 1'b1, 16'h0000, 16'h0, 2, 2);
    applyStimulus("ctrl_rd",    13'h1F00, 1'b0, 16'h0000, 16'h0000, 2, 2);
    applyStimulus("map_rd",     13'h0005, 1'b0, 16'h0000, 16'h0000, 2, 2);

`ifdef VMW_AUTOINC_EN
    $display("[TB] auto-increment port");
    applyStimulus("ptr_rst_rd", 13'h1F01, 1'b0, 16'h0, 16'h0000, 2, 2);
    applyStimulus("ptr_wr", 13'h1F01, 1'b1, 16'h1000, 16'h0, 2, 2);
    pushWrite(4'b0100, 11'd0, 64'hABC);
    applyStimulus("data_wr0", 13'h1F02, 1'b1, 16'h0ABC, 16'h0, 2, 2);
    pushWrite(4'b0100, 11'd1, 64'hDEF);
    applyStimulus("data_wr1", 13'h1F02, 1'b1, 16'h0DEF, 16'h0, 2, 2);
    applyStimulus("ptr_rd", 13'h1F01, 1'b0, 16'h0, 16'h1002, 2, 2);
    applyStimulus("data_rd", 13'h1F02, 1'b0, 16'h0, 16'h0000, 2, 2);
`else
    $display("[TB] auto-increment addresses unmapped");
    applyStimulus("ptr_unmap_wr", 13'h1F01, 1'b1, 16'h1000, 16'h0, 2, 2);
    applyStimulus("data_unmap_wr", 13'h1F02, 1'b1, 16'h0ABC, 16'h0, 2, 2);
    applyStimulus("ptr_unmap_rd", 13'h1F01, 1'b0, 16'h0, 16'h0000, 2, 2);
`endif

    $display("[TB] commanded clear with a request waiting");
    pushClear();
    busy_cycles = 0;
    applyStimulus("ctrl_clear", 13'h1F00, 1'b1, 16'h0001, 16'h0, 2, 2);
    pushWrite(4'b0100, 11'd0, 64'h777);
    applyStimulus("wait_paldef0", 13'h1000, 1'b1, 16'h0777, 16'h0, 1200, 1210);
    checkOutput("cmdclr_busycycles", 80'(busy_cycles), 80'(1200));
    checkOutput("cmdclr_drain", 80'(exp_q.size()), 80'(0));

    $display("[TB] reset in the middle of a clear");
    pushClear();
    applyStimulus("ctrl_clear2", 13'h1F00, 1'b1, 16'h0001, 16'h0, 2, 2);
    repeat (100) @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    checkOutput("midrst_busy", 80'(busy), 80'(0));
    checkOutput("midrst_we", 80'(mem_we), 80'(0));
    pushClear();
    busy_cycles = 0;
    @(negedge clk);
    resetn = 1'b1;
    waitClear("restart");

    checkOutput("final_drain", 80'(exp_q.size()), 80'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
